// File: rtl/y86_pipe_stage.sv
// rtl/y86_pipe_stage.sv - elastic Y86 pipeline stage register with 2-entry skid buffer
//
// Carries an icode plus an opaque payload between two pipeline stages using a
// valid/ready handshake. A main register M drives the outputs; a skid register S
// absorbs one beat while downstream stalls, so in_ready depends on registered state only.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready registered)
//   in_icode, in_data        upstream beat
//   flush                    synchronous squash of all held beats
//   out_valid/out_ready      downstream handshake
//   out_icode, out_data      presented beat (out_icode = NOP_ICODE when empty)
//   occupancy                beats held, 0..2
//
// Optional: define PIPE_STAGE_PERF_CNT_EN to add saturating stall_cnt/bubble_cnt outputs.

module y86_pipe_stage #(
    parameter int                 DATA_W    = 80,
    parameter int                 ICODE_W   = 8,
    parameter logic [ICODE_W-1:0] NOP_ICODE = 8'h01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ICODE_W-1:0] in_icode,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ICODE_W-1:0] out_icode,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);

    logic               m_v_q, m_v_d;
    logic               s_v_q, s_v_d;
    logic [ICODE_W-1:0] m_icode_q, m_icode_d;
    logic [DATA_W-1:0]  m_data_q, m_data_d;
    logic [ICODE_W-1:0] s_icode_q, s_icode_d;
    logic [DATA_W-1:0]  s_data_q, s_data_d;

    logic accept;
    logic drain;

    // in_ready comes straight from the skid valid flop: no path from out_ready.
    assign accept = in_valid & ~s_v_q;
    assign drain  = m_v_q & out_ready;

    always_comb begin
        m_v_d     = m_v_q;
        s_v_d     = s_v_q;
        m_icode_d = m_icode_q;
        m_data_d  = m_data_q;
        s_icode_d = s_icode_q;
        s_data_d  = s_data_q;
        if (flush) begin
            // Payload is left in place; only the valid bits and icode become a bubble.
            m_v_d     = 1'b0;
            s_v_d     = 1'b0;
            m_icode_d = NOP_ICODE;
        end else if (!m_v_q || drain) begin
            if (s_v_q) begin
                m_v_d     = 1'b1;
                m_icode_d = s_icode_q;
                m_data_d  = s_data_q;
                s_v_d     = 1'b0;
            end else if (accept) begin
                m_v_d     = 1'b1;
                m_icode_d = in_icode;
                m_data_d  = in_data;
            end else begin
                m_v_d     = 1'b0;
                m_icode_d = NOP_ICODE;
            end
        end else if (accept) begin
            s_v_d     = 1'b1;
            s_icode_d = in_icode;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v_q     <= 1'b0;
            s_v_q     <= 1'b0;
            m_icode_q <= NOP_ICODE;
            m_data_q  <= '0;
            s_icode_q <= '0;
            s_data_q  <= '0;
        end else begin
            m_v_q     <= m_v_d;
            s_v_q     <= s_v_d;
            m_icode_q <= m_icode_d;
            m_data_q  <= m_data_d;
            s_icode_q <= s_icode_d;
            s_data_q  <= s_data_d;
        end
    end

    assign in_ready  = ~s_v_q;
    assign out_valid = m_v_q;
    assign out_icode = m_icode_q;
    assign out_data  = m_data_q;
    assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (m_v_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!m_v_q && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_y86_pipe_stage.sv
// tb/tb_y86_pipe_stage.sv - self-checking bench for y86_pipe_stage

module tb_y86_pipe_stage;

    localparam int DATA_W  = 80;
    localparam int ICODE_W = 8;
    localparam logic [7:0] NOP = 8'h01;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_icode = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [7:0]        out_icode;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    y86_pipe_stage #(.DATA_W(DATA_W), .ICODE_W(ICODE_W), .NOP_ICODE(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_icode  (in_icode),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of held beats (at most two) plus the
    // payload last presented, which is what out_data shows while empty.
    typedef struct packed {
        logic [7:0]        icode;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             q[$];
    logic [DATA_W-1:0] last_data;
    longint            stall_m, bubble_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            last_data = '0;
            stall_m   = 0;
            bubble_m  = 0;
        end else begin
            bit    rdy;
            beat_t b;
            rdy = (q.size() < 2);
            if (q.size() > 0 && !out_ready) stall_m++;
            if (q.size() == 0) bubble_m++;
            if (flush) begin
                if (q.size() > 0) last_data = q[0].data;
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) begin
                    last_data = q[0].data;
                    void'(q.pop_front());
                end
                if (in_valid && rdy) begin
                    b.icode = in_icode;
                    b.data  = in_data;
                    q.push_back(b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic              ev;
            logic [7:0]        ei;
            logic [DATA_W-1:0] ed;
            logic              er;
            logic [1:0]        eo;
            ev = (q.size() > 0);
            ei = ev ? q[0].icode : NOP;
            ed = ev ? q[0].data : last_data;
            er = (q.size() < 2);
            eo = 2'(q.size());
            total++;
            if (out_valid !== ev || out_icode !== ei || out_data !== ed ||
                in_ready !== er || occupancy !== eo) begin
                bad++;
                $display("FAIL model_cmp t=%0t got v=%b ic=%h d=%h rdy=%b occ=%0d want v=%b ic=%h d=%h rdy=%b occ=%0d",
                         $time, out_valid, out_icode, out_data, in_ready, occupancy,
                         ev, ei, ed, er, eo);
            end
`ifdef PIPE_STAGE_PERF_CNT_EN
            total++;
            if (stall_cnt !== 32'(stall_m) || bubble_cnt !== 32'(bubble_m)) begin
                bad++;
                $display("FAIL perf_cnt got stall=%0d bubble=%0d want stall=%0d bubble=%0d",
                         stall_cnt, bubble_cnt, stall_m, bubble_m);
            end
`endif
        end
    end

    task automatic expect_out(input string name, input logic v, input logic [7:0] ic,
                              input logic rdy, input logic [1:0] occ);
        total++;
        if (out_valid !== v || out_icode !== ic || in_ready !== rdy || occupancy !== occ) begin
            bad++;
            $display("FAIL %s got v=%b ic=%h rdy=%b occ=%0d want v=%b ic=%h rdy=%b occ=%0d",
                     name, out_valid, out_icode, in_ready, occupancy, v, ic, rdy, occ);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, settle 2ns after it.
    task automatic step(input logic v, input logic [7:0] ic, input logic ordy, input logic fl);
        in_valid  = v;
        in_icode  = ic;
        in_data   = {ic, 72'(ic) * 72'h1_0001_0001};
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #12;
        rst = 1'b0;
        @(posedge clk);
        #2;
        expect_out("reset_idle", 1'b0, NOP, 1'b1, 2'd0);
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL reset_data got %h want 0", out_data);
        end

        // Streaming
        step(1, 8'h30, 1, 0); expect_out("stream_30", 1, 8'h30, 1, 2'd1);
        step(1, 8'h60, 1, 0); expect_out("stream_60", 1, 8'h60, 1, 2'd1);
        step(1, 8'h20, 1, 0); expect_out("stream_20", 1, 8'h20, 1, 2'd1);
        step(0, 8'h00, 1, 0); expect_out("stream_end", 0, NOP, 1, 2'd0);

        // Stall into skid, then drain
        step(1, 8'h40, 0, 0); expect_out("stall_a", 1, 8'h40, 1, 2'd1);
        step(1, 8'h50, 0, 0); expect_out("stall_b", 1, 8'h40, 0, 2'd2);
        step(1, 8'h55, 0, 0); expect_out("stall_hold", 1, 8'h40, 0, 2'd2);
        step(0, 8'h00, 1, 0); expect_out("drain_b", 1, 8'h50, 1, 2'd1);
        step(0, 8'h00, 1, 0); expect_out("drain_empty", 0, NOP, 1, 2'd0);

        // Flush with full skid, beat C offered the same cycle
        step(1, 8'h41, 0, 0);
        step(1, 8'h51, 0, 0); expect_out("flush_pre", 1, 8'h41, 0, 2'd2);
        step(1, 8'h70, 0, 1); expect_out("flush", 0, NOP, 1, 2'd0);
        step(0, 8'h00, 1, 0); expect_out("flush_no_c", 0, NOP, 1, 2'd0);

        // Async reset between edges while full
        step(1, 8'h42, 0, 0);
        step(1, 8'h52, 0, 0); expect_out("arst_pre", 1, 8'h42, 0, 2'd2);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        expect_out("arst_now", 0, NOP, 1, 2'd0);
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL arst_data got %h want 0", out_data);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #2;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_icode  = 8'($urandom);
            in_data   = {16'($urandom), $urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y86_pipe_stage.md
Name: y86_pipe_stage

Overview:
- Parametrised, elastic pipeline stage register for the Y86 pipeline.
- Successor to the fixed fetch/decode/execute/memory/writeback latches. Adds a valid/ready handshake, a 2-entry skid buffer, flush-to-bubble, and an occupancy output.
- Sits between any two pipeline stages. Carries an icode plus an opaque payload vector, for example valE/valM/dstE/dstM packed.

Parameters:
- DATA_W, 80, payload width in bits (default = 32 valE + 32 valM + 8 dstE + 8 dstM).
- ICODE_W, 8, icode field width.
- NOP_ICODE, 8'h01, icode presented on out_icode whenever the stage holds no valid beat (bubble).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered
- in_icode  in  ICODE_W  upstream icode
- in_data  in  DATA_W  upstream payload
- flush  in  1  synchronous squash of all held beats (mispredict/exception bubble)
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts; low = stall
- out_icode  out  ICODE_W  presented icode; NOP_ICODE when out_valid=0
- out_data  out  DATA_W  presented payload
- occupancy  out  2  beats held (0..2)

Behaviour:
- Storage:
  - main register M drives out_*.
  - skid register S holds one overflow beat.
  - Valid bits M_v, S_v.
- Reset (rst=1, asynchronous): M_v=0, S_v=0, out_valid=0, in_ready=1, out_icode=NOP_ICODE, out_data=0, occupancy=0, S contents=0. Outputs stay at these values while rst is held.
- Per-cycle terms:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready
- Update priority, evaluated at the clock edge: flush > normal transfer.
- flush=1:
  - M_v=0, S_v=0, out_icode=NOP_ICODE, out_data holds its value, in_ready=1.
  - Any beat accepted in the same cycle is discarded.
  - out_ready is ignored that cycle. The downstream stage still samples the current beat if it asserted out_ready.
- Normal transfer cases:
  - M empty or drain, S_v=1: M<=S, S_v<=0. An accept in this case is illegal, because in_ready=0 whenever S_v=1.
  - M empty or drain, S_v=0, accept: M<=input, M_v<=1.
  - M empty or drain, S_v=0, no accept: M_v<=0, out_icode<=NOP_ICODE, out_data holds.
  - M full, no drain, accept: S<=input, S_v<=1.
  - M full, no drain, no accept: hold everything.
- in_ready is registered and equals !S_v of the next state. There is no combinational path from out_ready to in_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 beat/cycle with out_ready=1 continuously.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- occupancy = M_v + S_v, registered with the state.
- out_data and out_icode are stable while out_valid=1 and out_ready=0.
- Asserting rst mid-stall discards both held beats immediately.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cnt [31:0]: increments each cycle with out_valid=1 and out_ready=0.
  - bubble_cnt [31:0]: increments each cycle with out_valid=0.
- Both counters saturate at 32'hFFFF_FFFF, clear on rst only, and are not affected by flush.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset and idle: assert rst, release, in_valid=0 -> out_valid=0, out_icode=8'h01, out_data=0, in_ready=1, occupancy=0.
- Streaming: in_valid=1, icode 8'h30/8'h60/8'h20 on consecutive cycles, out_ready=1 -> same icodes appear 1 cycle later in order, occupancy=1 throughout, no bubbles between beats.
- Stall into skid: beat A then beat B with out_ready=0 -> occupancy=2, in_ready=0 the cycle after B, out shows A stably. Raise out_ready -> A, then B, then out_valid=0 with out_icode=8'h01.
- Flush with full skid: occupancy=2, pulse flush with in_valid=1 carrying C -> next cycle out_valid=0, out_icode=8'h01, occupancy=0, in_ready=1, and C never appears.
- Async reset mid-stall: occupancy=2, assert rst between clock edges -> outputs go to reset values before the next edge.
- PIPE_STAGE_PERF_CNT_EN build: 5 stalled cycles followed by 3 empty cycles -> stall_cnt=5, bubble_cnt includes those 3. Force stall_cnt near 32'hFFFF_FFFF and keep stalling -> counter holds at 32'hFFFF_FFFF.
